m_imem_loader: RTL and testbench
================================

M_IMEM_LOADER -- requirements
Module: m_imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of 32-bit instruction words stored (power of two, 2..256).
REQ-002 The block SHALL have port w_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port w_rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port w_start, input, 1, a one-cycle request to begin a new load session.
REQ-005 The block SHALL have port w_in_valid, input, 1, meaning the instruction fields are valid.
REQ-006 The block SHALL have port w_in_ready, output, 1, meaning the block accepts fields this cycle.
REQ-007 The block SHALL have ports w_rd, w_rs1, w_rs2, input, 5 each, the R-type register fields.
REQ-008 The block SHALL have port w_op, input, 1: 0 = add, 1 = sub.
REQ-009 The block SHALL have port w_last, input, 1, qualified by valid&ready, marking the final instruction of the session.
REQ-010 The block SHALL have port w_done, output, 1, meaning a loaded program is available.
REQ-011 The block SHALL have port w_count, output, $clog2(DEPTH)+1, the number of words written in the current or last session.
REQ-012 The block SHALL have port w_raddr, input, 32, the byte address from the processor fetch stage.
REQ-013 The block SHALL have port w_rdata, output, 32, the instruction word, read asynchronously.

Function
REQ-014 The block SHALL encode each accepted entry as {funct7, rs2, rs1, 3'b000, rd, 7'b0110011}, with funct7 = 7'h00 for add and 7'h20 for sub.
REQ-015 The block SHALL implement states IDLE, LOAD and DONE.
REQ-016 IDLE: w_in_ready=0 and w_done=0; w_start moves the block to LOAD and clears w_count to 0.
REQ-017 LOAD: w_in_ready=1 while w_count<DEPTH; each cycle with w_in_valid&w_in_ready writes the encoded word to mem[w_count] and increments w_count by 1.
REQ-018 LOAD->DONE SHALL occur on the cycle after a write with w_last=1, or after the write that makes w_count==DEPTH (full), whichever comes first.
REQ-019 DONE: w_done=1 and w_in_ready=0; w_start restarts by clearing w_count and entering LOAD.
REQ-020 A w_start asserted in LOAD SHALL abort the session: w_count is cleared to 0 and any handshake in that same cycle is discarded (no write).
REQ-021 w_in_valid while w_in_ready=0 SHALL have no effect; the source holds its fields until accepted.
REQ-022 Read: the word index SHALL be w_raddr[31:2], with bits [1:0] ignored.
REQ-023 w_rdata SHALL be mem[index] when index<w_count; otherwise it SHALL be NOP 32'h00000033 (add x0,x0,x0), including all indices >= DEPTH.
REQ-024 Reads SHALL be combinational and valid in every state; a write at index i SHALL become visible in the cycle after acceptance.
REQ-025 Write latency SHALL be one cycle; throughput SHALL be one word per cycle.

Reset
REQ-026 While w_rst_n=0 the block SHALL be in IDLE with w_count=0, w_in_ready=0, w_done=0; w_rdata is therefore NOP for every address, and memory contents need no reset.
REQ-027 Reset asserted mid-LOAD SHALL discard the session immediately, without waiting for a clock edge.

Verification
REQ-028 Scenario: reset, start, then load add x5,x1,x2 / add x6,x3,x4 / sub x7,x5,x6 (last) -> rdata@0=0x002082B3, @4=0x00418333, @8=0x406283B3, @12=0x00000033; w_count=3; w_done=1.
REQ-029 Scenario: valid held with w_last never asserted, DEPTH=16 -> 16 writes; w_in_ready drops after the 16th write; DONE; rdata@0x40=0x00000033.
REQ-030 Scenario: valid toggled randomly during LOAD -> writes occur only on valid&ready cycles; w_count equals the handshake count.
REQ-031 Scenario: w_start during LOAD after 2 writes, with a simultaneous valid -> w_count=0; rdata@0=NOP next cycle; the fields offered that cycle are not written.
REQ-032 Scenario: w_rst_n low for 10 ns mid-LOAD, between clock edges -> w_in_ready=0 and w_count=0 immediately; rdata@0=NOP.
REQ-033 Scenario: w_raddr=0x00000006 after the load in REQ-028 -> rdata=0x00418333 (low bits ignored).

Source files
------------

// File: rtl/m_imem_loader.sv
// m_imem_loader: loads R-type add/sub instructions into a small instruction memory
// and serves combinational fetch reads, returning NOP past the loaded region.
module m_imem_loader #(
    parameter int DEPTH = 16
) (
    input  logic                     w_clk,
    input  logic                     w_rst_n,
    input  logic                     w_start,
    input  logic                     w_in_valid,
    output logic                     w_in_ready,
    input  logic [4:0]               w_rd,
    input  logic [4:0]               w_rs1,
    input  logic [4:0]               w_rs2,
    input  logic                     w_op,
    input  logic                     w_last,
    output logic                     w_done,
    output logic [$clog2(DEPTH):0]   w_count,
    input  logic [31:0]              w_raddr,
    output logic [31:0]              w_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LAST_SLOT = (AW + 1)'(DEPTH - 1);
    localparam logic [31:0] NOP = 32'h0000_0033;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] mem [DEPTH];
    logic        wr;
    logic [29:0] idx;
    logic        unused_lsbs;

    always_comb begin
        next_state = state;
        w_in_ready = (state == LOAD) && (w_count < FULL);
        w_done     = (state == DONE);
        // a start in the same cycle as a handshake aborts and drops that word
        wr         = w_in_ready && w_in_valid && !w_start;
        if (w_start)
            next_state = LOAD;
        else if (wr && (w_last || w_count == LAST_SLOT))
            next_state = DONE;
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state   <= IDLE;
            w_count <= '0;
        end else begin
            state <= next_state;
            if (w_start)
                w_count <= '0;
            else if (wr)
                w_count <= w_count + 1'b1;
        end
    end

    always_ff @(posedge w_clk) begin
        if (wr)
            mem[w_count[AW-1:0]] <= {w_op ? 7'h20 : 7'h00, w_rs2, w_rs1, 3'b000, w_rd, 7'b0110011};
    end

    // w_count never exceeds DEPTH, so index < w_count also bounds the memory index
    assign idx         = w_raddr[31:2];
    assign unused_lsbs = ^w_raddr[1:0];
    assign w_rdata     = ({{(29 - AW){1'b0}}, w_count} > idx) ? mem[idx[AW-1:0]] : NOP;
endmodule

// File: tb/tb_m_imem_loader.sv
// tb_m_imem_loader: directed, table-driven checks of the instruction memory loader.
module tb_m_imem_loader;
    localparam logic [31:0] NOP = 32'h0000_0033;

    typedef struct packed {
        logic        op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        last;
        logic [31:0] word;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } rd_t;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        w_start = 1'b0;
    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [4:0]  w_rd = '0;
    logic [4:0]  w_rs1 = '0;
    logic [4:0]  w_rs2 = '0;
    logic        w_op = 1'b0;
    logic        w_last = 1'b0;
    logic        w_done;
    logic [4:0]  w_count;
    logic [31:0] w_raddr = '0;
    logic [31:0] w_rdata;

    int total = 0;
    int passed = 0;

    m_imem_loader #(.DEPTH(16)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_start(w_start),
        .w_in_valid(w_in_valid), .w_in_ready(w_in_ready),
        .w_rd(w_rd), .w_rs1(w_rs1), .w_rs2(w_rs2), .w_op(w_op), .w_last(w_last),
        .w_done(w_done), .w_count(w_count), .w_raddr(w_raddr), .w_rdata(w_rdata)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [31:0] enc(input logic op, input logic [4:0] rd, rs1, rs2);
        return {op ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    task automatic tick;
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        w_raddr = addr;
        #1;
        chk(name, w_rdata, exp);
    endtask

    task automatic drive(input logic v, input logic op, input logic [4:0] rd, rs1, rs2, input logic last);
        w_in_valid = v;
        w_op = op;
        w_rd = rd;
        w_rs1 = rs1;
        w_rs2 = rs2;
        w_last = last;
    endtask

    task automatic pulse_start;
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
    endtask

    vec_t prog [3];
    rd_t  rds [8];

    initial begin
        int hs;
        logic [4:0] hs_last;
        prog[0] = '{1'b0, 5'd5, 5'd1, 5'd2, 1'b0, 32'h002082B3};
        prog[1] = '{1'b0, 5'd6, 5'd3, 5'd4, 1'b0, 32'h00418333};
        prog[2] = '{1'b1, 5'd7, 5'd5, 5'd6, 1'b1, 32'h406283B3};
        rds[0] = '{32'h0000_0000, 32'h002082B3};
        rds[1] = '{32'h0000_0004, 32'h00418333};
        rds[2] = '{32'h0000_0008, 32'h406283B3};
        rds[3] = '{32'h0000_000C, NOP};
        rds[4] = '{32'h0000_0006, 32'h00418333};
        rds[5] = '{32'h0000_0001, 32'h002082B3};
        rds[6] = '{32'h0000_0040, NOP};
        rds[7] = '{32'hFFFF_FFFC, NOP};

        #12;
        chk("reset ready", 32'(w_in_ready), 32'd0);
        chk("reset done", 32'(w_done), 32'd0);
        chk("reset count", 32'(w_count), 32'd0);
        rd_chk("reset rdata@0", 32'h0, NOP);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        drive(1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 1'b0);
        tick();
        chk("idle valid ignored count", 32'(w_count), 32'd0);
        chk("idle ready", 32'(w_in_ready), 32'd0);
        w_in_valid = 1'b0;

        pulse_start();
        chk("load ready", 32'(w_in_ready), 32'd1);
        chk("load count", 32'(w_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, prog[i].op, prog[i].rd, prog[i].rs1, prog[i].rs2, prog[i].last);
            tick();
            w_in_valid = 1'b0;
            chk($sformatf("prog count %0d", i), 32'(w_count), 32'(i + 1));
            rd_chk($sformatf("prog visible %0d", i), 32'(i * 4), prog[i].word);
        end
        chk("prog done", 32'(w_done), 32'd1);
        chk("prog ready", 32'(w_in_ready), 32'd0);
        for (int i = 0; i < 8; i++)
            rd_chk($sformatf("prog read %h", rds[i].addr), rds[i].addr, rds[i].data);
        drive(1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 1'b0);
        tick();
        w_in_valid = 1'b0;
        chk("done valid ignored", 32'(w_count), 32'd3);

        pulse_start();
        chk("restart count", 32'(w_count), 32'd0);
        chk("restart done", 32'(w_done), 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i[0], 5'(i), 5'(i + 1), 5'(31 - i), 1'b0);
            tick();
            chk($sformatf("full ready %0d", i), 32'(w_in_ready), 32'(i < 15));
            chk($sformatf("full done %0d", i), 32'(w_done), 32'(i == 15));
        end
        tick();
        w_in_valid = 1'b0;
        chk("full count", 32'(w_count), 32'd16);
        rd_chk("full rdata@0", 32'h0, enc(1'b0, 5'd0, 5'd1, 5'd31));
        rd_chk("full rdata@3c", 32'h3C, enc(1'b1, 5'd15, 5'd16, 5'd16));
        rd_chk("full rdata@40", 32'h40, NOP);

        pulse_start();
        hs = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 5'(hs), 5'd7, 5'd9, 1'b0);
            tick();
            if (w_in_valid) hs++;
            chk($sformatf("rand count %0d", i), 32'(w_count), 32'(hs));
        end
        w_in_valid = 1'b0;
        hs_last = 5'(hs - 1);
        rd_chk("rand beyond", 32'(hs * 4), NOP);
        if (hs > 0) rd_chk("rand last word", 32'((hs - 1) * 4), enc(1'b0, hs_last, 5'd7, 5'd9));

        pulse_start();
        drive(1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd4, 5'd5, 5'd6, 1'b0);
        tick();
        chk("abort pre count", 32'(w_count), 32'd2);
        drive(1'b1, 1'b1, 5'd10, 5'd11, 5'd12, 1'b1);
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        w_in_valid = 1'b0;
        chk("abort count", 32'(w_count), 32'd0);
        chk("abort ready", 32'(w_in_ready), 32'd1);
        chk("abort done", 32'(w_done), 32'd0);
        rd_chk("abort rdata@0", 32'h0, NOP);
        drive(1'b1, 1'b0, 5'd20, 5'd21, 5'd22, 1'b1);
        tick();
        w_in_valid = 1'b0;
        chk("after abort count", 32'(w_count), 32'd1);
        chk("after abort done", 32'(w_done), 32'd1);
        rd_chk("after abort rdata@0", 32'h0, enc(1'b0, 5'd20, 5'd21, 5'd22));

        pulse_start();
        drive(1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 1'b0);
        tick();
        tick();
        w_in_valid = 1'b0;
        chk("pre reset count", 32'(w_count), 32'd2);
        #1;
        w_rst_n = 1'b0;
        #1;
        chk("async reset ready", 32'(w_in_ready), 32'd0);
        chk("async reset count", 32'(w_count), 32'd0);
        chk("async reset done", 32'(w_done), 32'd0);
        rd_chk("async reset rdata@0", 32'h0, NOP);
        #8;
        w_rst_n = 1'b1;
        tick();
        chk("post reset idle ready", 32'(w_in_ready), 32'd0);
        chk("post reset count", 32'(w_count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
